// File: rtl/lc3_pkg.sv
// Shared ISA/ALU constants, FSM state type and the condition-code helper for the LC-3 ALU issue block.
// Optional HALT state is present only when LC3_ILLEGAL_TRAP_EN is defined.
package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASS1 = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3
`ifdef LC3_ILLEGAL_TRAP_EN
        , HALT    = 3'd4
`endif
    } state_t;

    function automatic logic [2:0] calc_nzp(input logic [15:0] r);
        calc_nzp = {r[15], r == 16'h0000, !r[15] && (r != 16'h0000)};
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 LC-3 general-purpose register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronous clear.
module lc3_regfile #(
    parameter int NREGS = 8,
    parameter int REG_W = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr0,
    output logic [REG_W-1:0] rd_data0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [REG_W-1:0] rd_data1,
    input  logic [AW-1:0]    dbg_addr,
    output logic [REG_W-1:0] dbg_data,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [REG_W-1:0] wr_data
);

    logic [REG_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write bypass: reads always see the value stored before the current edge.
    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/lc3_alu_issue_ctrl.sv
// LC-3 ALU initiator: accepts ADD/AND/NOT over valid/ready, drives the external ALU, writes back DR and NZP.
// Define LC3_ILLEGAL_TRAP_EN to trap unsupported instructions into a sticky HALT with an illegal flag.
module lc3_alu_issue_ctrl
    import lc3_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int REG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // An instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, so a held instr_valid waits without being consumed.
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [REG_W-1:0] alu_operand0,
    output logic [4:0]       alu_operand1,
    output logic [REG_W-1:0] alu_operand2,
    output logic             alu_sr2mux,
    output logic [1:0]       alu_opcode,
    input  logic [REG_W-1:0] alu_result,
    output logic             done,
    output logic [2:0]       nzp,
`ifdef LC3_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    input  logic [2:0]       dbg_addr,
    output logic [REG_W-1:0] dbg_data
);

    state_t           state;
    logic [15:0]      instr_q;
    logic [REG_W-1:0] result_q;
    logic [REG_W-1:0] sr1_data;
    logic [REG_W-1:0] sr2_data;
    logic             is_add;
    logic             is_and;
    logic             is_not;

    assign is_add = instr_q[15:12] == OP_ADD;
    assign is_and = instr_q[15:12] == OP_AND;
    assign is_not = (instr_q[15:12] == OP_NOT) && (instr_q[5:0] == 6'h3F);

    assign instr_ready = rst_n && (state == IDLE);
    assign done        = state == WRITEBACK;

    lc3_regfile #(
        .NREGS (NREGS),
        .REG_W (REG_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (instr_q[8:6]),
        .rd_data0 (sr1_data),
        .rd_addr1 (instr_q[2:0]),
        .rd_data1 (sr2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (state == WRITEBACK),
        .wr_addr  (instr_q[11:9]),
        .wr_data  (result_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            instr_q      <= '0;
            result_q     <= '0;
            alu_operand0 <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_sr2mux   <= 1'b0;
            alu_opcode   <= ALU_ADD;
            nzp          <= 3'b010;
`ifdef LC3_ILLEGAL_TRAP_EN
            illegal      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q <= instr;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_add || is_and) begin
                        alu_operand2 <= sr1_data;
                        alu_operand0 <= sr2_data;
                        alu_operand1 <= instr_q[4:0];
                        alu_sr2mux   <= instr_q[5];
                        alu_opcode   <= is_add ? ALU_ADD : ALU_AND;
                        state        <= EXECUTE;
                    end else if (is_not) begin
                        alu_operand0 <= sr1_data;
                        alu_operand2 <= sr1_data;
                        alu_operand1 <= instr_q[4:0];
                        alu_sr2mux   <= 1'b0;
                        alu_opcode   <= ALU_NOT;
                        state        <= EXECUTE;
                    end else begin
`ifdef LC3_ILLEGAL_TRAP_EN
                        illegal <= 1'b1;
                        state   <= HALT;
`else
                        state   <= IDLE;
`endif
                    end
                end
                EXECUTE: begin
                    result_q <= alu_result;
                    state    <= WRITEBACK;
                end
                WRITEBACK: begin
                    nzp   <= calc_nzp(result_q);
                    state <= IDLE;
                end
`ifdef LC3_ILLEGAL_TRAP_EN
                HALT: state <= HALT;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
